// File: rtl/integrate_dump_ctrl_if.sv
// Correlator sample stream in, valid/ready dump result out, for integrate_dump_ctrl.
// The master modport is the upstream/consumer side; the slave modport is the controller.
interface integrate_dump_ctrl_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) ();
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_i;
  logic signed [IN_W-1:0]  in_q;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_i;
  logic signed [ACC_W-1:0] out_q;

  modport master (
    output in_valid, in_i, in_q, out_ready,
    input  out_valid, out_i, out_q
  );

  modport slave (
    input  in_valid, in_i, in_q, out_ready,
    output out_valid, out_i, out_q
  );
endinterface

// File: rtl/integrate_dump_ctrl.sv
// Epoch-aligned coherent I/Q integrate-and-dump for one tracking channel.
// Define INTDUMP_ACC_SAT_EN for saturating accumulation and the sat_flag output.
module integrate_dump_ctrl #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] int_len,
  input  logic             epoch,
  integrate_dump_ctrl_if.slave bus,
  output logic [15:0]      dump_cnt,
  output logic             overrun,
`ifdef INTDUMP_ACC_SAT_EN
  output logic             sat_flag,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ALIGN, ACCUM} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        len, cnt, cnt_inc;
  logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
  logic signed [ACC_W-1:0] ext_i, ext_q;
  logic                    latch_len, clr, take, dump;

  assign busy    = (state != IDLE);
  assign cnt_inc = cnt + 1'b1;
  assign ext_i   = {{(ACC_W-IN_W){bus.in_i[IN_W-1]}}, bus.in_i};
  assign ext_q   = {{(ACC_W-IN_W){bus.in_q[IN_W-1]}}, bus.in_q};

`ifdef INTDUMP_ACC_SAT_EN
  logic sat_now, sat_seen, ovf_i, ovf_q;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic                    ovf
  );
    logic signed [ACC_W:0] s;
    s   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf = s[ACC_W] ^ s[ACC_W-1];
    if (ovf) sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else     sat_add = s[ACC_W-1:0];
  endfunction

  always_comb begin
    sum_i   = sat_add(acc_i, ext_i, ovf_i);
    sum_q   = sat_add(acc_q, ext_q, ovf_q);
    sat_now = ovf_i | ovf_q;
  end
`else
  assign sum_i = acc_i + ext_i;
  assign sum_q = acc_q + ext_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    latch_len = 1'b0;
    clr       = 1'b0;
    take      = 1'b0;
    unique case (state)
      IDLE: if (enable) begin
        latch_len = 1'b1;
        state_nxt = ALIGN;
      end
      ALIGN: if (!enable) begin
        clr       = 1'b1;
        state_nxt = IDLE;
      end else if (epoch) begin
        take      = bus.in_valid;
        state_nxt = ACCUM;
      end
      ACCUM: if (!enable) begin
        clr       = 1'b1;
        state_nxt = IDLE;
      end else begin
        take      = bus.in_valid;
      end
      default: state_nxt = IDLE;
    endcase
    dump = take && (cnt_inc == len);
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len           <= '0;
      cnt           <= '0;
      acc_i         <= '0;
      acc_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_i     <= '0;
      bus.out_q     <= '0;
      dump_cnt      <= '0;
      overrun       <= 1'b0;
`ifdef INTDUMP_ACC_SAT_EN
      sat_seen      <= 1'b0;
      sat_flag      <= 1'b0;
`endif
    end else begin
      if (latch_len) begin
        len      <= (int_len == '0) ? CNT_W'(1) : int_len;
        overrun  <= 1'b0;
        dump_cnt <= '0;
      end

      if (clr || dump) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
`ifdef INTDUMP_ACC_SAT_EN
        sat_seen <= 1'b0;
`endif
      end else if (take) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt_inc;
`ifdef INTDUMP_ACC_SAT_EN
        sat_seen <= sat_seen | sat_now;
`endif
      end

      // A new dump overwrites an unaccepted result and flags the loss.
      if (dump) begin
        bus.out_i     <= sum_i;
        bus.out_q     <= sum_q;
        bus.out_valid <= 1'b1;
        dump_cnt      <= dump_cnt + 16'd1;
        if (bus.out_valid && !bus.out_ready) overrun <= 1'b1;
`ifdef INTDUMP_ACC_SAT_EN
        sat_flag      <= sat_seen | sat_now;
`endif
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_integrate_dump_ctrl.sv
// Directed bench for integrate_dump_ctrl with ACC_W=20 so wrap/saturation is reachable.
// Build with +define+INTDUMP_ACC_SAT_EN to check the saturating variant.
module tb_integrate_dump_ctrl;
  localparam int IN_W  = 16;
  localparam int ACC_W = 20;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [CNT_W-1:0] int_len;
  logic             epoch;
  logic [15:0]      dump_cnt;
  logic             overrun;
  logic             busy;
`ifdef INTDUMP_ACC_SAT_EN
  logic             sat_flag;
`endif

  int n_checks = 0;
  int n_errors = 0;

  integrate_dump_ctrl_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

  integrate_dump_ctrl #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .int_len  (int_len),
    .epoch    (epoch),
    .bus      (bus),
    .dump_cnt (dump_cnt),
    .overrun  (overrun),
`ifdef INTDUMP_ACC_SAT_EN
    .sat_flag (sat_flag),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int i, input int q, input logic e);
    bus.in_valid = v;
    bus.in_i     = IN_W'(i);
    bus.in_q     = IN_W'(q);
    epoch        = e;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    int_len = '0;
    bus.out_ready = 1'b1;
    drive(1'b0, 0, 0, 1'b0);
    cyc();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_i", bus.out_i, 0);
    check("rst_dump_cnt", dump_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    cyc();

    // Basic run: len 4, I=100, Q=-50 every cycle, consumer always ready
    int_len = 16'd4; enable = 1'b1;
    cyc();
    check("basic_busy", busy, 1);
    drive(1'b1, 100, -50, 1'b0);
    repeat (3) cyc();
    check("basic_align_wait", bus.out_valid, 0);
    drive(1'b1, 100, -50, 1'b1);
    cyc();
    epoch = 1'b0;
    repeat (2) cyc();
    check("basic_no_early_dump", bus.out_valid, 0);
    cyc();
    check("basic_valid", bus.out_valid, 1);
    check("basic_out_i", bus.out_i, 400);
    check("basic_out_q", bus.out_q, -200);
    check("basic_dump_cnt", dump_cnt, 1);
`ifdef INTDUMP_ACC_SAT_EN
    check("basic_sat_flag", sat_flag, 0);
`endif
    cyc();
    check("basic_accepted", bus.out_valid, 0);
    repeat (3) cyc();
    check("basic_repeat_valid", bus.out_valid, 1);
    check("basic_repeat_i", bus.out_i, 400);
    check("basic_repeat_cnt", dump_cnt, 2);
    drive(1'b0, 0, 0, 1'b0); enable = 1'b0;
    cyc();
    check("basic_idle", busy, 0);

    // Gapped input with a mid-run epoch that must be ignored
    int_len = 16'd3; enable = 1'b1;
    cyc();
    check("gap_dump_cnt_clr", dump_cnt, 0);
    drive(1'b1, 1, 0, 1'b1); cyc();
    drive(1'b0, 0, 0, 1'b0); cyc();
    drive(1'b1, 2, 0, 1'b1); cyc();
    drive(1'b0, 0, 0, 1'b0); cyc();
    check("gap_no_early_dump", bus.out_valid, 0);
    drive(1'b1, 3, 0, 1'b0); cyc();
    check("gap_valid", bus.out_valid, 1);
    check("gap_out_i", bus.out_i, 6);
    check("gap_dump_cnt", dump_cnt, 1);
    drive(1'b0, 0, 0, 1'b0); enable = 1'b0;
    cyc();

    // Backpressure: two dumps while the consumer stalls
    bus.out_ready = 1'b0; int_len = 16'd2; enable = 1'b1;
    cyc();
    drive(1'b1, 5, 1, 1'b1); cyc();
    epoch = 1'b0; cyc();
    check("bp_first_i", bus.out_i, 10);
    check("bp_first_overrun", overrun, 0);
    drive(1'b1, 10, 1, 1'b0);
    repeat (2) cyc();
    check("bp_second_i", bus.out_i, 20);
    check("bp_second_valid", bus.out_valid, 1);
    check("bp_overrun", overrun, 1);
    drive(1'b0, 0, 0, 1'b0); bus.out_ready = 1'b1;
    cyc();
    check("bp_accepted", bus.out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    enable = 1'b0;
    cyc();
    check("bp_overrun_idle", overrun, 1);

    // Abort after 3 of 5 samples, then a fresh integration
    int_len = 16'd5; enable = 1'b1;
    cyc();
    check("abort_overrun_clr", overrun, 0);
    drive(1'b1, 7, 7, 1'b1); cyc();
    epoch = 1'b0;
    repeat (2) cyc();
    enable = 1'b0;
    cyc();
    check("abort_idle", busy, 0);
    check("abort_no_dump", bus.out_valid, 0);
    drive(1'b0, 0, 0, 1'b0); enable = 1'b1;
    cyc();
    drive(1'b1, 1, -1, 1'b1); cyc();
    epoch = 1'b0;
    repeat (4) cyc();
    check("abort_fresh_i", bus.out_i, 5);
    check("abort_fresh_q", bus.out_q, -5);
    check("abort_fresh_cnt", dump_cnt, 1);
    drive(1'b0, 0, 0, 1'b0); enable = 1'b0;
    cyc();

    // Wrap / saturate: 40 samples of full-scale input into a 20-bit accumulator
    int_len = 16'd40; enable = 1'b1;
    cyc();
    drive(1'b1, 32767, -32768, 1'b1); cyc();
    epoch = 1'b0; int_len = 16'd2;
    repeat (38) cyc();
    check("wrap_no_early_dump", bus.out_valid, 0);
    cyc();
    check("wrap_valid", bus.out_valid, 1);
`ifdef INTDUMP_ACC_SAT_EN
    check("sat_out_i", bus.out_i, 524287);
    check("sat_out_q", bus.out_q, -524288);
    check("sat_flag_set", sat_flag, 1);
`else
    check("wrap_out_i", bus.out_i, 262104);
    check("wrap_out_q", bus.out_q, -262144);
`endif
    drive(1'b0, 0, 0, 1'b0); enable = 1'b0;
    cyc();

    // int_len=0 acts as 1; accept and new dump in the same cycle
    int_len = 16'd0; enable = 1'b1;
    cyc();
    drive(1'b1, -3, 4, 1'b1); cyc();
    check("len0_valid", bus.out_valid, 1);
    check("len0_out_i", bus.out_i, -3);
    check("len0_out_q", bus.out_q, 4);
`ifdef INTDUMP_ACC_SAT_EN
    check("len0_sat_flag", sat_flag, 0);
`endif
    drive(1'b1, 9, 0, 1'b0); cyc();
    check("len0_b2b_valid", bus.out_valid, 1);
    check("len0_b2b_i", bus.out_i, 9);
    check("len0_b2b_overrun", overrun, 0);
    check("len0_b2b_cnt", dump_cnt, 2);

    // Asynchronous reset mid-ACCUM, between clock edges
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_i", bus.out_i, 0);
    check("arst_dump_cnt", dump_cnt, 0);
    check("arst_busy", busy, 0);
    cyc();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
